// File: rtl/prng_stream.sv
// prng_stream: dual-LFSR pseudo-random sample stream with tick divider and one-entry valid/ready buffer
module prng_stream #(
  parameter int DATA_W   = 16,
  parameter int TICK_DIV = 10_000_000,
  parameter int CNT_W    = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                step,
  input  logic                load_seed,
  input  logic [DATA_W-1:0]   seed_data,
  input  logic [DATA_W/2-1:0] seed_ctrl,
  input  logic                clear_ovr,
  output logic [DATA_W/2-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  output logic                tick_out
);
  localparam int OUT_W = DATA_W / 2;
  function automatic logic [31:0] tap_mask(input int w);
    return w == 4  ? 32'h0000_000C :
           w == 8  ? 32'h0000_00B8 :
           w == 12 ? 32'h0000_0829 :
           w == 16 ? 32'h0000_D008 :
           w == 24 ? 32'h00E1_0000 :
           w == 32 ? 32'h8020_0003 : 32'h0;
  endfunction
  localparam logic [DATA_W-1:0] D_TAPS = DATA_W'(tap_mask(DATA_W));
  localparam logic [OUT_W-1:0]  C_TAPS = OUT_W'(tap_mask(OUT_W));
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);
  if (!(DATA_W inside {8, 16, 24, 32})) begin : g_bad_width
    $error("prng_stream: DATA_W must be 8, 16, 24 or 32");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("prng_stream: TICK_DIV must be at least 2");
  end
  logic [DATA_W-1:0] data_q;
  logic [OUT_W-1:0]  ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pend_q;
  logic              run, tick, adv_d, adv_c, offer, accept, drop;
  logic [OUT_W-1:0]  mux_out;
  assign run    = en && !load_seed;
  assign tick   = run && mode == 2'b00 && cnt_q == CNT_MAX;
  assign adv_d  = run && (mode == 2'b00 ? tick : mode == 2'b01 && step);
  assign adv_c  = run && (mode == 2'b00 || (mode == 2'b01 && step));
  assign offer  = pend_q && run;
  assign accept = offer && (!out_valid || out_ready);
  assign drop   = offer && out_valid && !out_ready;
  // pair-select: each control bit picks the odd or even bit of a data pair
  always_comb begin
    mux_out = '0;
    for (int j = 0; j < OUT_W; j++) mux_out[j] = ctrl_q[j] ? data_q[2*j+1] : data_q[2*j];
  end
  // both LFSRs: seed load (all-ones lockup replaced by zero) or XNOR-feedback left shift
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (load_seed) begin
      data_q <= &seed_data ? '0 : seed_data;
      ctrl_q <= &seed_ctrl ? '0 : seed_ctrl;
    end else begin
      if (adv_d) data_q <= {data_q[DATA_W-2:0], ~^(data_q & D_TAPS)};
      if (adv_c) ctrl_q <= {ctrl_q[OUT_W-2:0], ~^(ctrl_q & C_TAPS)};
    end
  end
  // free-run divider, restarting from zero whenever free-run is not active
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      tick_out <= 1'b0;
    end else begin
      cnt_q    <= (!run || mode != 2'b00 || tick) ? '0 : cnt_q + 1'b1;
      tick_out <= tick;
    end
  end
  // pending flag: a data advance offers its sample on the following edge; frozen while disabled
  always_ff @(posedge clk) begin
    if (reset || load_seed) pend_q <= 1'b0;
    else if (en) pend_q <= adv_d;
  end
  // one-entry output buffer with sticky overrun on dropped samples
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) out_data <= mux_out;
      out_valid <= !load_seed && (accept || (out_valid && !out_ready));
      overrun   <= drop || (overrun && !clear_ovr);
    end
  end
endmodule

// File: tb/tb_prng_stream.sv
// tb_prng_stream: directed vector table plus multi-cycle tick sequences for prng_stream
module tb_prng_stream;
  logic        clk = 1'b0;
  logic        reset, en, step, load_seed, clear_ovr, out_ready;
  logic [1:0]  mode;
  logic [15:0] seed_data;
  logic [7:0]  seed_ctrl, out_data;
  logic        out_valid, overrun, tick_out;
  int checks = 0, failures = 0;
  typedef struct {
    logic rst, en; logic [1:0] mode; logic step, ld; logic [15:0] sd; logic [7:0] sc; logic clr, rdy;
    logic v; logic [7:0] d; logic o, t;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  prng_stream #(.DATA_W(16), .TICK_DIV(4), .CNT_W(24)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .step(step), .load_seed(load_seed),
    .seed_data(seed_data), .seed_ctrl(seed_ctrl), .clear_ovr(clear_ovr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun), .tick_out(tick_out)
  );
  function automatic vec_t mk(logic rst, logic e, logic [1:0] m, logic s, logic ld, logic [15:0] sd,
                              logic [7:0] sc, logic clr, logic rdy, logic v, logic [7:0] d, logic o, logic t);
    vec_t r;
    r.rst = rst; r.en = e; r.mode = m; r.step = s; r.ld = ld; r.sd = sd; r.sc = sc; r.clr = clr; r.rdy = rdy;
    r.v = v; r.d = d; r.o = o; r.t = t;
    return r;
  endfunction
  task automatic tick_wait(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tick_out && n < 10);
  endtask
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  initial begin
    int n;
    //            rst en mode st ld sd        sc     clr rdy   v  d      o  t
    vq.push_back(mk(1, 0, 2'd0, 0, 0, 16'h0,    8'h0,  0, 0,   0, 8'h00, 0, 0)); // 0 reset
    vq.push_back(mk(0, 1, 2'd1, 0, 1, 16'h0,    8'h0,  0, 1,   0, 8'h00, 0, 0)); // 1 seed 0/0
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 1,   0, 8'h00, 0, 0)); // 2 data=0001
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 1,   1, 8'h00, 0, 0)); // 3
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 1,   1, 8'h01, 0, 0)); // 4 load on consume
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 1,   1, 8'h01, 0, 0)); // 5
    vq.push_back(mk(0, 1, 2'd1, 0, 0, 16'h0,    8'h0,  0, 1,   1, 8'h03, 0, 0)); // 6
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 1,   0, 8'h03, 0, 0)); // 7 data=001E
    vq.push_back(mk(0, 1, 2'd1, 0, 0, 16'h0,    8'h0,  0, 1,   1, 8'h02, 0, 0)); // 8
    vq.push_back(mk(0, 1, 2'd1, 0, 1, 16'hFFFF, 8'hFF, 0, 0,   0, 8'h02, 0, 0)); // 9 lockup seeds
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 1,   0, 8'h02, 0, 0)); // 10
    vq.push_back(mk(0, 1, 2'd1, 0, 0, 16'h0,    8'h0,  0, 1,   1, 8'h00, 0, 0)); // 11
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 0,   1, 8'h00, 0, 0)); // 12
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 0,   1, 8'h00, 1, 0)); // 13 drop
    vq.push_back(mk(0, 1, 2'd1, 0, 0, 16'h0,    8'h0,  0, 0,   1, 8'h00, 1, 0)); // 14 drop
    vq.push_back(mk(0, 1, 2'd1, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h00, 1, 0)); // 15 consume
    vq.push_back(mk(0, 1, 2'd1, 0, 0, 16'h0,    8'h0,  1, 1,   0, 8'h00, 0, 0)); // 16 clear
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 0,   0, 8'h00, 0, 0)); // 17
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 0,   1, 8'h03, 0, 0)); // 18
    vq.push_back(mk(0, 1, 2'd1, 0, 0, 16'h0,    8'h0,  1, 0,   1, 8'h03, 1, 0)); // 19 clear+drop
    vq.push_back(mk(0, 1, 2'd1, 0, 0, 16'h0,    8'h0,  1, 1,   0, 8'h03, 0, 0)); // 20
    vq.push_back(mk(0, 1, 2'd0, 0, 1, 16'h0,    8'h0,  0, 1,   0, 8'h03, 0, 0)); // 21 reseed, free-run
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h03, 0, 0)); // 22
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h03, 0, 0)); // 23
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h03, 0, 0)); // 24
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h03, 0, 1)); // 25 tick
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   1, 8'h00, 0, 0)); // 26
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h00, 0, 0)); // 27
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h00, 0, 0)); // 28
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h00, 0, 1)); // 29 tick
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   1, 8'h01, 0, 0)); // 30
    vq.push_back(mk(0, 0, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h01, 0, 0)); // 31 en=0
    vq.push_back(mk(0, 0, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h01, 0, 0)); // 32
    vq.push_back(mk(0, 0, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h01, 0, 0)); // 33
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h01, 0, 0)); // 34
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h01, 0, 0)); // 35
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h01, 0, 0)); // 36
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h01, 0, 1)); // 37 tick
    vq.push_back(mk(0, 1, 2'd0, 0, 0, 16'h0,    8'h0,  0, 1,   1, 8'h01, 0, 0)); // 38
    vq.push_back(mk(0, 1, 2'd1, 1, 0, 16'h0,    8'h0,  0, 1,   0, 8'h01, 0, 0)); // 39 pending set
    vq.push_back(mk(1, 1, 2'd1, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h00, 0, 0)); // 40 reset
    vq.push_back(mk(0, 1, 2'd1, 0, 0, 16'h0,    8'h0,  0, 1,   0, 8'h00, 0, 0)); // 41 no sample
    reset = 1'b1; en = 1'b0; mode = 2'd0; step = 1'b0; load_seed = 1'b0;
    seed_data = '0; seed_ctrl = '0; clear_ovr = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    foreach (vq[i]) begin
      reset = vq[i].rst; en = vq[i].en; mode = vq[i].mode; step = vq[i].step; load_seed = vq[i].ld;
      seed_data = vq[i].sd; seed_ctrl = vq[i].sc; clear_ovr = vq[i].clr; out_ready = vq[i].rdy;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_data, overrun, tick_out} !== {vq[i].v, vq[i].d, vq[i].o, vq[i].t}) begin
        failures++;
        $display("FAIL row%0d got v=%0b d=%h o=%0b t=%0b exp v=%0b d=%h o=%0b t=%0b", i,
                 out_valid, out_data, overrun, tick_out, vq[i].v, vq[i].d, vq[i].o, vq[i].t);
      end
    end
    reset = 1'b0; en = 1'b1; mode = 2'd0; step = 1'b0; load_seed = 1'b0; clear_ovr = 1'b0; out_ready = 1'b1;
    tick_wait(n);
    chk("first_tick_cycles", n, 4);
    @(posedge clk); #1;
    chk("tick_sample", {out_valid, out_data}, {1'b1, 8'h00});
    mode = 2'd2;
    @(posedge clk); #1;
    mode = 2'd0;
    tick_wait(n);
    chk("tick_after_mode_change", n, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
